// File: rtl/num_to_ascii_pkg.sv
// rtl/num_to_ascii_pkg.sv - shared states, ASCII and radix constants for num_to_ascii
package num_ascii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        SIGN,
        EMIT,
        DONE
    } state_t;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    localparam int RADIX_DEC = 10;
    localparam int RADIX_HEX = 16;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        if (d < 4'd10)
            return CH_ZERO + {4'd0, d};
        else
            return CH_A + {4'd0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/num_to_ascii_if.sv
// rtl/num_to_ascii_if.sv - start/busy/done request and result bundle for num_to_ascii
interface num_to_ascii_if #(
    parameter int DATA_W    = 32,
    parameter int MAX_CHARS = 11,
    parameter int LEN_W     = 8
);
    logic                   start;
    logic [DATA_W-1:0]      x;
    logic                   is_signed;
    logic                   hex_mode;
    logic                   busy;
    logic                   done;
    logic [8*MAX_CHARS-1:0] ans;
    logic [LEN_W-1:0]       length;

    modport master (
        output start, x, is_signed, hex_mode,
        input  busy, done, ans, length
    );

    modport slave (
        input  start, x, is_signed, hex_mode,
        output busy, done, ans, length
    );
endinterface

// File: rtl/num_to_ascii_divmod.sv
// rtl/num_to_ascii_divmod.sv - one-digit divide/modulo step by 10 or 16
module digit_divmod
    import num_ascii_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] v,
    input  logic              hex_mode,
    output logic [DATA_W-1:0] quot,
    output logic [3:0]        rem
);

    always_comb begin
        quot = v / DATA_W'(RADIX_DEC);
        rem  = 4'(v % DATA_W'(RADIX_DEC));
        if (hex_mode) begin
            quot = v >> $clog2(RADIX_HEX);
            rem  = 4'(v & DATA_W'(RADIX_HEX - 1));
        end
    end

endmodule

// File: rtl/num_to_ascii.sv
// rtl/num_to_ascii.sv - sequential binary to ASCII converter, decimal/hex, optional sign
module num_to_ascii
    import num_ascii_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_CHARS = 11,
    parameter int LEN_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    num_to_ascii_if.slave bus
);

    localparam int DW = $clog2(MAX_CHARS + 1);

    state_t                 state, state_n;
    logic [DATA_W-1:0]      v;
    logic [DATA_W-1:0]      quot;
    logic [3:0]             rem;
    logic                   neg;
    logic                   is_signed_q;
    logic                   hex_q;
    logic [3:0]             dbuf [MAX_CHARS];
    logic [DW-1:0]          dcnt;
    logic [8*MAX_CHARS-1:0] ans_q;
    logic [LEN_W-1:0]       len_q;
    logic                   busy_q;
    logic                   done_q;

    digit_divmod #(.DATA_W(DATA_W)) u_divmod (
        .v        (v),
        .hex_mode (hex_q),
        .quot     (quot),
        .rem      (rem)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = LOAD;
            LOAD:    state_n = DIVIDE;
            DIVIDE:  if (quot == '0) state_n = neg ? SIGN : EMIT;
            SIGN:    state_n = EMIT;
            EMIT:    if (dcnt == DW'(1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ans_q  <= '0;
            len_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == EMIT) && (state_n == DONE);
            if ((state == EMIT) && (state_n == DONE))
                busy_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        v           <= bus.x;
                        is_signed_q <= bus.is_signed;
                        hex_q       <= bus.hex_mode;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    // Negation in DATA_W bits leaves the most-negative value as its own magnitude
                    neg   <= is_signed_q & v[DATA_W-1];
                    v     <= (is_signed_q & v[DATA_W-1]) ? -v : v;
                    ans_q <= '0;
                    len_q <= '0;
                    dcnt  <= '0;
                end
                DIVIDE: begin
                    dbuf[dcnt] <= rem;
                    dcnt       <= dcnt + DW'(1);
                    v          <= quot;
                end
                SIGN: begin
                    ans_q[7:0] <= CH_MINUS;
                    len_q      <= LEN_W'(1);
                end
                EMIT: begin
                    for (int i = 0; i < MAX_CHARS; i++)
                        if (LEN_W'(i) == len_q)
                            ans_q[8*i +: 8] <= digit_char(dbuf[dcnt - DW'(1)]);
                    len_q <= len_q + LEN_W'(1);
                    dcnt  <= dcnt - DW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ans    = ans_q;
    assign bus.length = len_q;

endmodule
